// File: rtl/snes_frame_sync_ctrl_pkg.sv
// Shared types and defaults for the SNES-to-HDMI frame alignment logic.
// The line constants match the ones the HDMI converter uses.
package snes_frame_sync_ctrl_pkg;

    localparam int         PAUSE_W        = 20;
    localparam logic [7:0] DEF_SYNC_LINE  = 8'd2;
    localparam logic [7:0] DEF_REARM_LINE = 8'd200;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        PAUSED = 2'd1,
        DONE   = 2'd2
    } sync_state_e;

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [PAUSE_W-1:0] sat_inc(input logic [PAUSE_W-1:0] v,
                                                   input logic [PAUSE_W-1:0] lim);
        return (v >= lim) ? lim : v + PAUSE_W'(1);
    endfunction

endpackage

// File: rtl/snes_frame_sync_ctrl_if.sv
// Core-side pause/status bundle of the frame sync controller.
// The master side is the controller; the slave side is the SNES core / debug overlay.
interface snes_frame_sync_ctrl_if;
    import snes_frame_sync_ctrl_pkg::*;

    logic               enable;
    logic [8:0]         ys;
    logic               snes_refresh;
    logic               hdmi_first_line;
    logic               pause_snes_for_frame_sync;
    logic               sync_locked;
    logic               timeout_err;
    logic [PAUSE_W-1:0] pause_cycles;
    logic               pause_valid;

    modport master (
        input  enable, ys, snes_refresh, hdmi_first_line,
        output pause_snes_for_frame_sync, sync_locked, timeout_err, pause_cycles, pause_valid
    );

    modport slave (
        output enable, ys, snes_refresh, hdmi_first_line,
        input  pause_snes_for_frame_sync, sync_locked, timeout_err, pause_cycles, pause_valid
    );

endinterface

// File: rtl/snes_frame_sync_ctrl_sync_rise_det.sv
// Level synchronizer for a clk_pixel signal followed by a registered rising-edge pulse.
// Pulse appears STAGES+1 clk after the input transition.
module sync_rise_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/snes_frame_sync_ctrl.sv
// Stalls the SNES core once per frame on the refresh slot of SYNC_LINE and releases it on the
// HDMI first-active-line rise (or a timeout), reporting lock status and measured pause length.
module snes_frame_sync_ctrl
    import snes_frame_sync_ctrl_pkg::*;
#(
    parameter logic [7:0]         SYNC_LINE      = DEF_SYNC_LINE,
    parameter logic [7:0]         REARM_LINE     = DEF_REARM_LINE,
    parameter logic [PAUSE_W-1:0] TIMEOUT_CYCLES = 20'd900000,
    parameter logic [3:0]         LOCK_FRAMES    = 4'd4,
    parameter int                 SYNC_STAGES    = 2
) (
    input logic                    clk,
    input logic                    reset,
    snes_frame_sync_ctrl_if.master bus
);

    sync_state_e        state_q, state_d;
    logic [PAUSE_W-1:0] cnt_q, cnt_d;
    logic [PAUSE_W-1:0] pcyc_q, pcyc_d;
    logic [3:0]         lock_q, lock_d;
    logic               pause_q, pause_d;
    logic               locked_q, locked_d;
    logic               terr_q, terr_d;
    logic               pvalid_q, pvalid_d;
    logic               hdmi_rise;
    logic               unused_ys_field;

    assign unused_ys_field = bus.ys[8];

    sync_rise_det #(.STAGES(SYNC_STAGES)) u_hdmi_rise (
        .clk      (clk),
        .reset    (reset),
        .async_in (bus.hdmi_first_line),
        .rise     (hdmi_rise)
    );

    // cnt_q is zero only in the entry cycle of PAUSED, so a rise there is ignored.
    // pause_cycles counts the cycles the pause output was high, including the release cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pcyc_d   = pcyc_q;
        lock_d   = lock_q;
        pause_d  = pause_q;
        terr_d   = terr_q;
        pvalid_d = 1'b0;
        if (!bus.enable) begin
            state_d = ARMED;
            pause_d = 1'b0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (bus.ys[7:0] == SYNC_LINE && bus.snes_refresh) begin
                        state_d = PAUSED;
                        pause_d = 1'b1;
                        cnt_d   = '0;
                    end
                end
                PAUSED: begin
                    cnt_d = sat_inc(cnt_q, TIMEOUT_CYCLES);
                    if (hdmi_rise && cnt_q != '0) begin
                        state_d  = DONE;
                        pause_d  = 1'b0;
                        pcyc_d   = sat_inc(cnt_q, TIMEOUT_CYCLES);
                        pvalid_d = 1'b1;
                        if (lock_q < LOCK_FRAMES) lock_d = lock_q + 4'd1;
                    end else if (cnt_q == TIMEOUT_CYCLES - PAUSE_W'(1)) begin
                        state_d  = DONE;
                        pause_d  = 1'b0;
                        pcyc_d   = TIMEOUT_CYCLES;
                        pvalid_d = 1'b1;
                        terr_d   = 1'b1;
                        lock_d   = '0;
                    end
                end
                DONE: begin
                    if (bus.ys[7:0] == REARM_LINE) state_d = ARMED;
                end
                default: begin
                    state_d = ARMED;
                    pause_d = 1'b0;
                end
            endcase
        end
        locked_d = (lock_d == LOCK_FRAMES);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARMED;
            cnt_q    <= '0;
            pcyc_q   <= '0;
            lock_q   <= '0;
            pause_q  <= 1'b0;
            locked_q <= 1'b0;
            terr_q   <= 1'b0;
            pvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pcyc_q   <= pcyc_d;
            lock_q   <= lock_d;
            pause_q  <= pause_d;
            locked_q <= locked_d;
            terr_q   <= terr_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign bus.pause_snes_for_frame_sync = pause_q;
    assign bus.sync_locked               = locked_q;
    assign bus.timeout_err               = terr_q;
    assign bus.pause_cycles              = pcyc_q;
    assign bus.pause_valid               = pvalid_q;

endmodule
